serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial, LSB-first adder/subtractor with a start/done handshake.
- Loads two WIDTH-bit operands and an operation select, then resolves one bit per clock through a single full-adder cell and carry flop.
- Presents the parallel sum and carry-out when finished.
- Sequential, area-minimal counterpart of the lab's combinational ripple add/sub datapath; its bench reuses the same operand vectors.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).
- CNT_W, 3, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- k  input  1  operation: 0 = x+y, 1 = x−y; captured with start
- x  input  WIDTH  operand A; captured with start
- y  input  WIDTH  operand B; captured with start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse when result is valid
- s  output  WIDTH  result; held stable from done until the next accepted start
- cout  output  1  final carry; for subtract, 1 = no borrow (x ≥ y unsigned)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, done=0, s=0, cout=0, counter=0, carry flop=0, operand registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at a clk edge: capture x into shift register A, capture (k ? ~y : y) into shift register B.
  - Carry flop := k; counter := 0; go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each cycle:
  - sum bit = A[0]^B[0]^c; new carry = majority(A[0], B[0], c).
  - Sum bit shifts into the result register MSB end, result shifts right; A and B shift right.
  - Counter increments. Leaving the cycle with counter = WIDTH−1 → DONE.
  - Exactly WIDTH cycles in SHIFT.
- DONE: done=1 for exactly one cycle; cout := final carry; then go to IDLE.
- Latency: start accepted at edge N → busy high for edges N+1…N+WIDTH → done high in cycle after edge N+WIDTH (WIDTH+1 cycles start-to-done).
- s is updated only at the DONE transition; intermediate shifting uses an internal register, so s never shows partial results.
- start while busy or in DONE: ignored, no effect on the operation in progress. No queuing.
- k, x, y changes after acceptance: no effect.
- Back-to-back: start may be asserted in the cycle done is high; it is sampled in the following IDLE cycle (one idle cycle minimum between operations).
- Wrap-around: results are modulo 2^WIDTH; the carry out of the MSB appears only on cout.
- Reset mid-operation: immediate abort to the reset values; no done pulse.

Optional Feature:
- Macro: SERIAL_ADDSUB_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), two's-complement signed overflow = carry-into-MSB XOR carry-out-of-MSB.
  - Registered at the DONE transition alongside s.
  - Held with s; reset to 0.
- Undefined: no ovf port and no related logic; all other behaviour identical.

Test Plan:
- Reset check: assert rst_n=0 mid-SHIFT → busy=0, done=0, s=0, cout=0 immediately. Release and start k=0, x=4'b1110, y=4'b1100 → done after 5 cycles, s=4'b1010, cout=1.
- Add k=0, x=4'b1101, y=4'b0010 → s=4'b1111, cout=0; busy high exactly 4 cycles.
- Subtract k=1, x=4'b1101, y=4'b0010 → s=4'b1011, cout=1. Then k=1, x=4'b1101, y=4'b0110 → s=4'b0111, cout=1.
- Borrow case: k=1, x=4'b0010, y=4'b1101 → s=4'b0101, cout=0.
- Handshake: pulse start again during SHIFT with different operands → ignored; result matches the first operands. Start held through done → next operation begins from IDLE; s holds the old value until the new done.
- With SERIAL_ADDSUB_OVF_EN:
  - k=0, x=4'b0111, y=4'b0001 → s=4'b1000, ovf=1, cout=0.
  - k=1, x=4'b1000, y=4'b0001 → s=4'b0111, ovf=1.

Source files
------------

// File: rtl/serial_addsub_if.sv
// Handshake/operand bundle for serial_addsub; the ovf wire exists only with SERIAL_ADDSUB_OVF_EN.
// The requester uses the master modport and the adder uses the slave modport.
interface serial_addsub_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             k;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic             ovf;

    modport master (output start, k, x, y, input busy, done, s, cout, ovf);
    modport slave  (input start, k, x, y, output busy, done, s, cout, ovf);
`else
    modport master (output start, k, x, y, input busy, done, s, cout);
    modport slave  (input start, k, x, y, output busy, done, s, cout);
`endif
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial LSB-first add/sub through one full-adder cell; SERIAL_ADDSUB_OVF_EN adds a signed-overflow flag.
// Latency: WIDTH+1 cycles from the accepted start to the one-cycle done pulse.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or in DONE (no queuing).
module serial_addsub #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_s;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             w_sum;
    logic             w_carry;
    logic             w_last;

    assign w_sum   = r_a[0] ^ r_b[0] ^ r_c;
    assign w_carry = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start) w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE:                 w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic r_ovf;

    // On the last shift r_c is the carry into the MSB and w_carry the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_SHIFT && w_last) begin
            r_ovf <= r_c ^ w_carry;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // Subtract is x + ~y + 1: invert y on load and seed the carry with k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_s    <= '0;
            r_cnt  <= '0;
            r_c    <= 1'b0;
            r_cout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.x;
                        r_b   <= bus.k ? ~bus.y : bus.y;
                        r_c   <= bus.k;
                        r_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_carry;
                    r_acc <= {w_sum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_s    <= {w_sum, r_acc[WIDTH-1:1]};
                        r_cout <= w_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.s    = r_s;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub: table-driven operations plus reset, ignored-start and held-start sequences.
module tb_serial_addsub;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;
    logic [W-1:0] prev_s;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         k;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operands are scrambled right after acceptance; the result must not change.
    task automatic run_op(input string tag, input logic k, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int   cyc;
        int   bcnt;
        logic seen;
        logic stable;
        cyc = 0; bcnt = 0; seen = 1'b0; stable = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.k = k; bus.x = x; bus.y = y;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus.start = 1'b0; bus.k = ~k; bus.x = ~x; bus.y = y + 4'd3;
            end
            if (bus.busy) begin
                bcnt++;
                if (bus.s !== prev_s) stable = 1'b0;
            end
            if (bus.done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(W));
        chk({tag, "_s_stable_while_busy"}, 32'(stable), 32'd1);
        chk({tag, "_s"}, 32'(bus.s), 32'(es));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("note: %s has no overflow reference", tag);
`endif
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
        chk({tag, "_s_hold"}, 32'(bus.s), 32'(es));
        prev_s = es;
    endtask

    initial begin
        int   cyc;
        int   d1;
        int   d2;
        logic seen;
        logic hold_ok;

        n_vec = 0; n_bad = 0; prev_s = '0;
        bus.start = 1'b0; bus.k = 1'b0; bus.x = '0; bus.y = '0;

        vt[0]  = '{1'b0, 4'b1110, 4'b1100, 4'b1010, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 4'b1101, 4'b0010, 4'b1111, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 4'b1101, 4'b0010, 4'b1011, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 4'b1101, 4'b0110, 4'b0111, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 4'b0010, 4'b1101, 4'b0101, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};
        vt[8]  = '{1'b1, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0};
        vt[10] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

        rst_n = 1'b0;
        #12;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_s", 32'(bus.s), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", 32'(bus.busy), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("v%0d", i), vt[i].k, vt[i].x, vt[i].y, vt[i].s, vt[i].c, vt[i].o);
        end

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        bus.start = 1'b1; bus.k = 1'b0; bus.x = 4'b1110; bus.y = 4'b1100;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("mid_busy_before_rst", 32'(bus.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_done", 32'(bus.done), 32'd0);
        chk("mid_rst_s", 32'(bus.s), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done) seen = 1'b1;
        end
        chk("mid_rst_no_done", 32'(seen), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_s = '0;
        run_op("after_rst", 1'b0, 4'b1110, 4'b1100, 4'b1010, 1'b1, 1'b0);

        // A second start pulse during SHIFT must be ignored and not queued.
        @(negedge clk);
        bus.start = 1'b1; bus.k = 1'b0; bus.x = 4'b1101; bus.y = 4'b0010;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (cyc == 2) begin
                bus.start = 1'b1; bus.k = 1'b1; bus.x = 4'b0001; bus.y = 4'b0001;
            end
            if (cyc == 3) bus.start = 1'b0;
            if (bus.done) seen = 1'b1;
        end
        chk("ign_latency", 32'(cyc), 32'(W + 1));
        chk("ign_s", 32'(bus.s), 32'b1111);
        chk("ign_cout", 32'(bus.cout), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("ign_not_queued", 32'(bus.busy), 32'd0);
        prev_s = 4'b1111;

        // start held high through done: second op begins from IDLE, old s held until new done.
        @(negedge clk);
        bus.start = 1'b1; bus.k = 1'b1; bus.x = 4'b1101; bus.y = 4'b0010;
        cyc = 0; d1 = 0; d2 = 0; hold_ok = 1'b1;
        while (d2 == 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                bus.k = 1'b0; bus.x = 4'b0111; bus.y = 4'b0001;
            end
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = cyc;
                    chk("held_first_s", 32'(bus.s), 32'b1011);
                    chk("held_first_cout", 32'(bus.cout), 32'd1);
                end else begin
                    d2 = cyc;
                end
            end else if (d1 != 0 && bus.s !== 4'b1011) begin
                hold_ok = 1'b0;
            end
        end
        chk("held_first_done_cycle", 32'(d1), 32'(W + 1));
        chk("held_second_done_cycle", 32'(d2), 32'(2 * W + 3));
        chk("held_s_kept", 32'(hold_ok), 32'd1);
        chk("held_second_s", 32'(bus.s), 32'b1000);
        chk("held_second_cout", 32'(bus.cout), 32'd0);
        bus.start = 1'b0;
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
